// File: rtl/timer_responder.sv
// timer_responder
// Memory-mapped timer peripheral answering the core's req/we/select/ready
// register handshake. Provides a prescaled free-running counter, a compare
// match flag with optional auto-reload and a level interrupt.
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   reg_req       initiator request, held until reg_ready is seen
//   reg_we        1 = write, 0 = read (sampled at acceptance)
//   reg_select    word register index (sampled at acceptance)
//   reg_data_in   write data (sampled at acceptance)
//   reg_data_out  read data, valid while reg_ready is high
//   reg_ready     one-cycle completion pulse
//   irq           level interrupt, STATUS.match & CTRL.ie
//
// Register map: 0 CTRL {ie, auto_reload, en}, 1 COUNT, 2 COMPARE,
// 3 STATUS {match} (write 1 to clear), 4 PRESCALE, 5..7 read as zero.
module timer_responder #(
  parameter int M_WIDTH     = 32,
  parameter int ACC_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_req,
  input  logic               reg_we,
  input  logic [2:0]         reg_select,
  input  logic [M_WIDTH-1:0] reg_data_in,
  output logic [M_WIDTH-1:0] reg_data_out,
  output logic               reg_ready,
  output logic               irq
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(ACC_LATENCY - 1);

  state_t             state;
  logic [3:0]         wait_cnt;
  logic               lat_we;
  logic [2:0]         lat_sel;
  logic [M_WIDTH-1:0] lat_data;

  logic               ctrl_en;
  logic               ctrl_ar;
  logic               ctrl_ie;
  logic [M_WIDTH-1:0] count;
  logic [M_WIDTH-1:0] compare;
  logic               match;
  logic [M_WIDTH-1:0] prescale;
  logic [M_WIDTH-1:0] ps_cnt;

  logic               access;
  logic               wr_fire;
  logic               wr_ctrl;
  logic               wr_count;
  logic               wr_compare;
  logic               wr_status;
  logic               wr_prescale;
  logic               en_eff;
  logic               tick;
  logic               hit;
  logic [M_WIDTH-1:0] rd_value;

  // The access (register update or read capture) happens on the edge that
  // ends the last BUSY cycle.
  assign access      = (state == BUSY) && (wait_cnt == 4'd0);
  assign wr_fire     = access && lat_we;
  assign wr_ctrl     = wr_fire && (lat_sel == 3'd0);
  assign wr_count    = wr_fire && (lat_sel == 3'd1);
  assign wr_compare  = wr_fire && (lat_sel == 3'd2);
  assign wr_status   = wr_fire && (lat_sel == 3'd3);
  assign wr_prescale = wr_fire && (lat_sel == 3'd4);

  // A CTRL write clearing en suppresses a tick on the very same edge.
  assign en_eff = ctrl_en && !(wr_ctrl && !lat_data[0]);
  assign tick   = en_eff && (ps_cnt == prescale);
  assign hit    = tick && (count == compare);

  assign irq = match & ctrl_ie;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // latch is inferred for unlisted select values.
  always_comb begin
    rd_value = '0;
    case (lat_sel)
      3'd0:    rd_value = {{(M_WIDTH-3){1'b0}}, ctrl_ie, ctrl_ar, ctrl_en};
      3'd1:    rd_value = count;
      3'd2:    rd_value = compare;
      3'd3:    rd_value = {{(M_WIDTH-1){1'b0}}, match};
      3'd4:    rd_value = prescale;
      default: rd_value = '0;
    endcase
  end

  // Bus-side handshake FSM with registered reg_ready / reg_data_out.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      lat_we       <= 1'b0;
      lat_sel      <= '0;
      lat_data     <= '0;
      reg_ready    <= 1'b0;
      reg_data_out <= '0;
    end else begin
      reg_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (reg_req) begin
            lat_we   <= reg_we;
            lat_sel  <= reg_select;
            lat_data <= reg_data_in;
            wait_cnt <= WAIT_INIT;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // reg_req is deliberately ignored here: a dropped request still
          // completes and pulses reg_ready.
          if (wait_cnt == 4'd0) begin
            reg_ready    <= 1'b1;
            reg_data_out <= lat_we ? '0 : rd_value;
            state        <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE:    state <= RELEASE;
        RELEASE: if (!reg_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Timer datapath. Register writes take priority over same-edge counting.
  // NOTE: the synchronous reset clears every timer register; there is no
  // memory array here, so nothing is left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en  <= 1'b0;
      ctrl_ar  <= 1'b0;
      ctrl_ie  <= 1'b0;
      count    <= '0;
      compare  <= '0;
      match    <= 1'b0;
      prescale <= '0;
      ps_cnt   <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en <= lat_data[0];
        ctrl_ar <= lat_data[1];
        ctrl_ie <= lat_data[2];
      end

      if (wr_count || wr_prescale) begin
        ps_cnt <= '0;
      end else if (en_eff) begin
        ps_cnt <= tick ? '0 : ps_cnt + M_WIDTH'(1);
      end

      if (wr_count) begin
        count <= lat_data;
      end else if (tick) begin
        count <= (hit && ctrl_ar) ? '0 : count + M_WIDTH'(1);
      end

      if (wr_compare)  compare  <= lat_data;
      if (wr_prescale) prescale <= lat_data;

      // A new match beats a same-edge write-1-clear.
      if (hit) begin
        match <= 1'b1;
      end else if (wr_status && lat_data[0]) begin
        match <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_responder.sv
module tb_timer_responder;

  localparam int L1 = 1;
  localparam int L2 = 4;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        reg_req, reg_we, req2, we2;
  logic [2:0]  reg_select, sel2;
  logic [31:0] reg_data_in, reg_data_out, din2, dout2;
  logic        reg_ready, irq, ready2, irq2;

  int checks = 0;
  int errors = 0;

  // Reference state of the timer as seen by software.
  logic [2:0]  m_ctrl;      // {ie, auto_reload, en}
  logic [31:0] m_count, m_compare, m_prescale, m_ps;
  logic        m_match;

  always #5 clk = ~clk;

  timer_responder #(.M_WIDTH(32), .ACC_LATENCY(L1)) dut (
    .clk(clk), .rst(rst), .reg_req(reg_req), .reg_we(reg_we),
    .reg_select(reg_select), .reg_data_in(reg_data_in),
    .reg_data_out(reg_data_out), .reg_ready(reg_ready), .irq(irq)
  );

  timer_responder #(.M_WIDTH(32), .ACC_LATENCY(L2)) dut2 (
    .clk(clk), .rst(rst2), .reg_req(req2), .reg_we(we2),
    .reg_select(sel2), .reg_data_in(din2),
    .reg_data_out(dout2), .reg_ready(ready2), .irq(irq2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] sel);
    case (sel)
      3'd0:    return {29'd0, m_ctrl};
      3'd1:    return m_count;
      3'd2:    return m_compare;
      3'd3:    return {31'd0, m_match};
      3'd4:    return m_prescale;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_count = '0; m_compare = '0; m_prescale = '0; m_ps = '0; m_match = 1'b0;
  endtask

  // One clock of the timer: advance the prescaler, count on a tick, then
  // let a software write (if one lands on this edge) override.
  task automatic model_edge(input bit wr, input logic [2:0] sel, input logic [31:0] d);
    bit en, tick, hit;
    en   = m_ctrl[0] && !(wr && sel == 3'd0 && !d[0]);
    tick = en && (m_ps == m_prescale);
    hit  = tick && (m_count == m_compare);
    if (en)   m_ps    = tick ? 32'd0 : m_ps + 32'd1;
    if (tick) m_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
    if (hit)  m_match = 1'b1;
    if (wr) begin
      case (sel)
        3'd0: m_ctrl = d[2:0];
        3'd1: begin m_count = d; m_ps = 32'd0; end
        3'd2: m_compare = d;
        3'd3: if (d[0] && !hit) m_match = 1'b0;
        3'd4: begin m_prescale = d; m_ps = 32'd0; end
        default: ;
      endcase
    end
  endtask

  // Advance one clock; wr says whether dut's access lands on this edge.
  task automatic step(input bit wr, input logic [2:0] sel, input logic [31:0] d);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(wr, sel, d);
    #1;
    check("irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0);
  endtask

  // Full transaction on dut: latency, pulse, data and release are checked.
  task automatic access(input bit we, input logic [2:0] sel, input logic [31:0] d,
                        input int hold, output logic [31:0] rd);
    logic [31:0] exp;
    exp = 32'd0;
    reg_req = 1'b1; reg_we = we; reg_select = sel; reg_data_in = d;
    for (int e = 1; e <= L1 + 1; e++) begin
      if (e == L1 + 1) begin
        exp = we ? 32'd0 : model_read(sel);
        step(we, sel, d);
      end else begin
        step(1'b0, sel, d);
        check("ready_early", {31'd0, reg_ready}, 32'd0);
      end
    end
    check("ready_pulse", {31'd0, reg_ready}, 32'd1);
    check("rdata", reg_data_out, exp);
    rd = reg_data_out;
    for (int h = 0; h < hold; h++) begin
      idle(1);
      check("ready_hold", {31'd0, reg_ready}, 32'd0);
      check("rdata_hold", reg_data_out, exp);
    end
    reg_req = 1'b0; reg_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle(1);
      check("ready_release", {31'd0, reg_ready}, 32'd0);
    end
  endtask

  // Transaction on dut2 (ACC_LATENCY = 4), whose timer stays disabled.
  task automatic access2(input bit we, input logic [2:0] sel, input logic [31:0] d,
                         output logic [31:0] rd);
    req2 = 1'b1; we2 = we; sel2 = sel; din2 = d;
    for (int e = 1; e <= L2 + 1; e++) begin
      idle(1);
      if (e <= L2) check("ready2_early", {31'd0, ready2}, 32'd0);
    end
    check("ready2_pulse", {31'd0, ready2}, 32'd1);
    rd = dout2;
    req2 = 1'b0; we2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle(1);
      check("ready2_release", {31'd0, ready2}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  sel;
    logic [31:0] d;
    bit          we;

    rst = 1'b1; rst2 = 1'b1;
    reg_req = 1'b0; reg_we = 1'b0; reg_select = '0; reg_data_in = '0;
    req2 = 1'b0; we2 = 1'b0; sel2 = '0; din2 = '0;
    model_reset();
    idle(3);
    check("reset_ready", {31'd0, reg_ready}, 32'd0);
    check("reset_rdata", reg_data_out, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0; rst2 = 1'b0;
    idle(1);

    // Every register reads zero after reset.
    for (int s = 0; s < 8; s++) begin
      access(1'b0, 3'(s), 32'd0, 0, rd);
      check("reset_read", rd, 32'd0);
    end

    // Prescaled counting, compare match with auto-reload, interrupt.
    access(1'b1, 3'd4, 32'd3, 0, rd);
    access(1'b1, 3'd2, 32'd5, 0, rd);
    access(1'b1, 3'd0, 32'h7, 0, rd);
    for (int i = 0; i < 100 && !m_match; i++) idle(1);
    check("irq_on_match", {31'd0, irq}, 32'd1);
    access(1'b0, 3'd3, 32'd0, 0, rd);
    check("status_set", rd, 32'd1);
    access(1'b0, 3'd1, 32'd0, 0, rd);
    access(1'b0, 3'd1, 32'd0, 0, rd);
    access(1'b1, 3'd3, 32'd1, 0, rd);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // Match on the all-ones to zero wrap, no auto-reload.
    access(1'b1, 3'd0, 32'h0, 0, rd);
    access(1'b1, 3'd3, 32'd1, 0, rd);
    access(1'b1, 3'd2, 32'hFFFF_FFFF, 0, rd);
    access(1'b1, 3'd1, 32'hFFFF_FFFE, 0, rd);
    access(1'b1, 3'd4, 32'd0, 0, rd);
    access(1'b1, 3'd0, 32'h1, 0, rd);
    access(1'b0, 3'd3, 32'd0, 0, rd);
    check("wrap_match", rd, 32'd1);
    access(1'b0, 3'd1, 32'd0, 0, rd);
    check("count_after_wrap", rd, 32'd5);

    // A request held for many cycles is serviced once.
    access(1'b0, 3'd2, 32'd0, 9, rd);
    check("held_read", rd, 32'hFFFF_FFFF);

    // Write-1-clear of STATUS landing on the same edge as a match.
    access(1'b1, 3'd0, 32'h0, 0, rd);
    access(1'b1, 3'd1, 32'd0, 0, rd);
    access(1'b1, 3'd2, 32'd3, 0, rd);
    access(1'b1, 3'd3, 32'd1, 0, rd);
    access(1'b1, 3'd0, 32'h5, 0, rd);
    access(1'b1, 3'd3, 32'd1, 0, rd);
    check("clear_vs_match_irq", {31'd0, irq}, 32'd1);
    access(1'b0, 3'd3, 32'd0, 0, rd);
    check("clear_vs_match_status", rd, 32'd1);
    // COUNT write on a tick edge (PRESCALE = 0 ticks every cycle).
    access(1'b1, 3'd1, 32'h100, 0, rd);
    access(1'b0, 3'd1, 32'd0, 0, rd);
    check("count_write_wins", rd, 32'h103);

    // Reset during BUSY of a write on the ACC_LATENCY = 4 instance.
    access2(1'b0, 3'd2, 32'd0, rd);
    check("dut2_compare_init", rd, 32'd0);
    req2 = 1'b1; we2 = 1'b1; sel2 = 3'd2; din2 = 32'hA5;
    idle(2);
    rst2 = 1'b1;
    idle(1);
    check("dut2_ready_in_reset", {31'd0, ready2}, 32'd0);
    rst2 = 1'b0; req2 = 1'b0; we2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("dut2_no_pulse", {31'd0, ready2}, 32'd0);
    end
    access2(1'b0, 3'd2, 32'd0, rd);
    check("dut2_compare_discarded", rd, 32'd0);
    check("dut2_irq", {31'd0, irq2}, 32'd0);

    // Random register traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      sel = 3'($urandom_range(0, 7));
      we  = 1'($urandom_range(0, 1));
      case (sel)
        3'd0:    d = 32'($urandom_range(0, 7));
        3'd1:    d = 32'($urandom_range(0, 20));
        3'd2:    d = 32'($urandom_range(0, 20));
        3'd3:    d = 32'($urandom_range(0, 1));
        3'd4:    d = 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      access(we, sel, d, $urandom_range(0, 3), rd);
      idle($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
